adc_conv_sequencer: RTL and testbench
=====================================

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, ADC period/count width.
REQ-002 SHALL have parameter NUM_CH, default 4, analog input channels.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, ADC-held-in-reset cycles after a mux change.
REQ-004 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per channel.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- Start_i  in  1  scan request, sampled in IDLE only.
- Abort_i  in  1  cancel the current scan.
- Channel_mask_i  in  NUM_CH  channels to scan.
- Period_cfg_i  in  W  PWM period for the scan.
- Period_counter_val_o  out  W  period driven to the ADC core.
- Adc_reset_o  out  1  active-high reset to the ADC core.
- Mux_sel_o  out  CH_W=clog2(NUM_CH)  analog mux select.
- On_counter_val_i  in  W  ADC result.
- ADC_valid_strb_i  in  1  ADC result strobe.
- Result_o  out  W; Result_ch_o  out  CH_W; Result_valid_o  out  1; Result_ready_i  in  1.
- Busy_o  out  1; Scan_done_o  out  1  one-cycle pulse.

Function
REQ-006 SHALL implement states IDLE, SELECT, SETTLE, CONVERT, OUTPUT, DONE.
REQ-007 IDLE: Start_i=1 and Channel_mask_i!=0 SHALL latch mask and Period_cfg_i, set the pointer to the lowest set bit, and enter SELECT; Busy_o=1 from the next cycle.
REQ-008 Start_i with mask 0 SHALL be ignored: no Busy_o, no Scan_done_o; Start_i outside IDLE SHALL be ignored.
REQ-009 SELECT: one cycle; Mux_sel_o SHALL take the pointer value and Adc_reset_o=1; then enter SETTLE.
REQ-010 SETTLE: Adc_reset_o SHALL stay 1 for exactly SETTLE_CYCLES cycles, then enter CONVERT with Adc_reset_o=0.
REQ-011 CONVERT: the first ADC_valid_strb_i SHALL be discarded as a partial period; each later strobe SHALL add On_counter_val_i to a W+AVG_LOG2-bit accumulator with no overflow.
REQ-012 After 2^AVG_LOG2 accepted samples, Result_o SHALL be set to accumulator>>AVG_LOG2 (truncate), Result_ch_o to the pointer, and the state SHALL become OUTPUT.
REQ-013 OUTPUT: Adc_reset_o=1; Result_valid_o=1; Result_o and Result_ch_o SHALL stay stable until Result_valid_o&Result_ready_i; strobes SHALL be ignored.
REQ-014 On the OUTPUT handshake, the next set mask bit above the pointer SHALL lead to SELECT; if there is none, the state SHALL become DONE.
REQ-015 DONE: Scan_done_o=1 for one cycle, then IDLE with Busy_o=0.
REQ-016 Period_counter_val_o SHALL hold the latched period for the whole scan and be unaffected by later Period_cfg_i changes.
REQ-017 Abort_i in any non-IDLE state SHALL go to IDLE next cycle: Adc_reset_o=1, Result_valid_o=0, no Scan_done_o, accumulator cleared; Abort_i has priority over the handshake.
REQ-018 A strobe in the same cycle as the SETTLE->CONVERT transition SHALL be ignored, not counted as the discarded strobe.

Reset
REQ-019 reset SHALL override all inputs, including Abort_i.
REQ-020 On reset the state SHALL be IDLE with Busy_o=0, Adc_reset_o=1, Period_counter_val_o=0, Mux_sel_o=0, Result_o=0, Result_ch_o=0, Result_valid_o=0, Scan_done_o=0, accumulator and counters 0.
REQ-021 Reset mid-scan, including during OUTPUT, SHALL drop the pending result without a handshake.

Configuration
REQ-022 Macro ADC_SEQ_AVG_EN defined: averaging per REQ-011/012.
REQ-023 Macro ADC_SEQ_AVG_EN undefined: no accumulator, AVG_LOG2 ignored, the first non-discarded sample taken directly as Result_o.

Structure
REQ-024 Package adc_seq_pkg SHALL hold the state enum type and the CH_W/accumulator width helper constants.
REQ-025 Sub-module adc_seq_avg (accumulate, count, shift) SHALL be instantiated only under ADC_SEQ_AVG_EN.

Verification (NUM_CH=4, SETTLE_CYCLES=8, AVG_LOG2=2)
REQ-026 Verification SHALL cover:
- Mask 4'b0101, macro on, strobes 50(discarded),100,104,108,112 -> Result_o=106, Result_ch_o=0; then ch2 via SELECT, Adc_reset_o high 1+8 cycles; Scan_done_o after ch2.
- Result_ready_i low 10 cycles in OUTPUT with strobes -> Result_valid_o/Result_o/Result_ch_o stable, Adc_reset_o=1, no accumulation.
- Abort_i during CONVERT -> next cycle IDLE, Busy_o=0, Adc_reset_o=1, no Result_valid_o, no Scan_done_o.
- Start_i with mask 0, then Start_i pulse during SETTLE -> no scan started, no extra scan queued.
- reset asserted in OUTPUT -> all outputs at REQ-020 values next cycle.
- Macro on, four strobes of 16'hFFFF -> Result_o=16'hFFFF; macro off, single 16'hFFFF -> Result_o=16'hFFFF.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state type and width helpers for the ADC conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONVERT,
    ST_OUTPUT,
    ST_DONE
  } seq_state_e;

  localparam int DEF_W             = 16;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_AVG_LOG2      = 2;

  // Mux select width; a single channel still needs one select bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Accumulator width that holds 2**avg_log2 full-scale samples without overflow.
  function automatic int acc_width(input int w, input int avg_log2);
    return w + avg_log2;
  endfunction

endpackage

// File: rtl/adc_seq_avg.sv
// adc_seq_avg: accumulates 2**AVG_LOG2 accepted ADC samples and presents the
// truncated mean together with the sample that completes the set.
module adc_seq_avg
  import adc_seq_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         sample_en_i,
  input  logic [W-1:0] sample_i,
  output logic         last_o,
  output logic [W-1:0] avg_o
);

  localparam int ACC_W = acc_width(W, AVG_LOG2);
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_d;
  logic [CNT_W-1:0] cnt_q;

  assign sum_d  = acc_q + ACC_W'(sample_i);
  assign last_o = sample_en_i && (cnt_q == CNT_LAST);
  assign avg_o  = W'(sum_d >> AVG_LOG2);

  // Accumulate accepted samples; the set restarts empty once the mean is taken.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (sample_en_i) begin
      if (cnt_q == CNT_LAST) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= sum_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: scans the channels of a mask through one ADC core,
// settling the mux with the ADC held in reset, then returning one result per
// channel over a valid/ready handshake.
// Build option: define ADC_SEQ_AVG_EN to average 2**AVG_LOG2 samples per
// channel; otherwise the first non-discarded sample is the result.
//
// state   | meaning
// IDLE    | waiting for Start_i with a non-empty mask
// SELECT  | mux driven to the current channel, ADC held in reset
// SETTLE  | ADC held in reset for SETTLE_CYCLES while the input settles
// CONVERT | ADC running; first strobe discarded, later ones sampled
// OUTPUT  | result presented, ADC held in reset until the handshake
// DONE    | one-cycle scan-complete pulse
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int W             = DEF_W,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int AVG_LOG2      = DEF_AVG_LOG2,
  localparam int CH_W         = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start_i,
  input  logic              Abort_i,
  input  logic [NUM_CH-1:0] Channel_mask_i,
  input  logic [W-1:0]      Period_cfg_i,
  output logic [W-1:0]      Period_counter_val_o,
  output logic              Adc_reset_o,
  output logic [CH_W-1:0]   Mux_sel_o,
  input  logic [W-1:0]      On_counter_val_i,
  input  logic              ADC_valid_strb_i,
  output logic [W-1:0]      Result_o,
  output logic [CH_W-1:0]   Result_ch_o,
  output logic              Result_valid_o,
  input  logic              Result_ready_i,
  output logic              Busy_o,
  output logic              Scan_done_o
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_e        state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   mux_sel_q;
  logic [W-1:0]      period_q;
  logic [W-1:0]      result_q;
  logic [CH_W-1:0]   result_ch_q;
  logic [SET_W-1:0]  settle_q;
  logic              adc_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              discard_q;

  logic [CH_W-1:0]   first_ptr_d;
  logic [CH_W-1:0]   next_ptr_d;
  logic              next_found_d;

  logic              sample_en;
  logic              sample_last;
  logic [W-1:0]      sample_val;

  // Lowest set bit of the requested mask becomes the first channel.
  always_comb begin
    first_ptr_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (Channel_mask_i[i]) first_ptr_d = CH_W'(i);
    end
  end

  // Next latched channel strictly above the current pointer, if any.
  always_comb begin
    next_ptr_d   = '0;
    next_found_d = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (CH_W'(i) > ptr_q)) begin
        next_ptr_d   = CH_W'(i);
        next_found_d = 1'b1;
      end
    end
  end

  // The first strobe of each conversion covers a partial PWM period and is dropped.
  assign sample_en = (state_q == ST_CONVERT) && ADC_valid_strb_i && !discard_q && !Abort_i;

`ifdef ADC_SEQ_AVG_EN
  adc_seq_avg #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (Abort_i || (state_q != ST_CONVERT)),
    .sample_en_i (sample_en),
    .sample_i    (On_counter_val_i),
    .last_o      (sample_last),
    .avg_o       (sample_val)
  );
`else
  logic unused_avg;
  assign unused_avg  = (AVG_LOG2 > 0);
  assign sample_last = sample_en;
  assign sample_val  = On_counter_val_i;
`endif

  // Scan sequencing with registered outputs; abort beats every in-scan transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      ptr_q       <= '0;
      mux_sel_q   <= '0;
      period_q    <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      settle_q    <= '0;
      adc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      discard_q   <= 1'b0;
    end else if (Abort_i && (state_q != ST_IDLE)) begin
      state_q     <= ST_IDLE;
      adc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_i && (|Channel_mask_i)) begin
            mask_q      <= Channel_mask_i;
            period_q    <= Period_cfg_i;
            ptr_q       <= first_ptr_d;
            mux_sel_q   <= first_ptr_d;
            adc_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          settle_q <= SET_W'(SETTLE_CYCLES - 1);
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            adc_reset_q <= 1'b0;
            discard_q   <= 1'b1;
            state_q     <= ST_CONVERT;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        ST_CONVERT: begin
          if (ADC_valid_strb_i) begin
            discard_q <= 1'b0;
            if (sample_last) begin
              result_q    <= sample_val;
              result_ch_q <= ptr_q;
              valid_q     <= 1'b1;
              adc_reset_q <= 1'b1;
              state_q     <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (Result_ready_i) begin
            valid_q <= 1'b0;
            if (next_found_d) begin
              ptr_q     <= next_ptr_d;
              mux_sel_q <= next_ptr_d;
              state_q   <= ST_SELECT;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Period_counter_val_o = period_q;
  assign Adc_reset_o          = adc_reset_q;
  assign Mux_sel_o            = mux_sel_q;
  assign Result_o             = result_q;
  assign Result_ch_o          = result_ch_q;
  assign Result_valid_o       = valid_q;
  assign Busy_o               = busy_q;
  assign Scan_done_o          = done_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: randomized scans against a per-channel averaging model.
module tb_adc_conv_sequencer;

  localparam int W        = 16;
  localparam int NUM_CH   = 4;
  localparam int SETTLE   = 8;
  localparam int AVG_LOG2 = 2;
`ifdef ADC_SEQ_AVG_EN
  localparam int N_AVG = 1 << AVG_LOG2;
`else
  localparam int N_AVG = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic        Abort_i;
  logic [3:0]  Channel_mask_i;
  logic [15:0] Period_cfg_i;
  logic [15:0] Period_counter_val_o;
  logic        Adc_reset_o;
  logic [1:0]  Mux_sel_o;
  logic [15:0] On_counter_val_i;
  logic        ADC_valid_strb_i;
  logic [15:0] Result_o;
  logic [1:0]  Result_ch_o;
  logic        Result_valid_o;
  logic        Result_ready_i;
  logic        Busy_o;
  logic        Scan_done_o;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          done_seen = 0;
  int          done_exp  = 0;
  logic [15:0] cur_period;

  adc_conv_sequencer #(
    .W             (W),
    .NUM_CH        (NUM_CH),
    .SETTLE_CYCLES (SETTLE),
    .AVG_LOG2      (AVG_LOG2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .Start_i              (Start_i),
    .Abort_i              (Abort_i),
    .Channel_mask_i       (Channel_mask_i),
    .Period_cfg_i         (Period_cfg_i),
    .Period_counter_val_o (Period_counter_val_o),
    .Adc_reset_o          (Adc_reset_o),
    .Mux_sel_o            (Mux_sel_o),
    .On_counter_val_i     (On_counter_val_i),
    .ADC_valid_strb_i     (ADC_valid_strb_i),
    .Result_o             (Result_o),
    .Result_ch_o          (Result_ch_o),
    .Result_valid_o       (Result_valid_o),
    .Result_ready_i       (Result_ready_i),
    .Busy_o               (Busy_o),
    .Scan_done_o          (Scan_done_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (Scan_done_o) done_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_busy"},    Busy_o, 0);
    chk({pfx, "_adc_rst"}, Adc_reset_o, 1);
    chk({pfx, "_period"},  Period_counter_val_o, 0);
    chk({pfx, "_mux"},     Mux_sel_o, 0);
    chk({pfx, "_result"},  Result_o, 0);
    chk({pfx, "_res_ch"},  Result_ch_o, 0);
    chk({pfx, "_valid"},   Result_valid_o, 0);
    chk({pfx, "_done"},    Scan_done_o, 0);
  endtask

  task automatic start_scan(input logic [3:0] mask);
    cur_period     = 16'($urandom);
    Start_i        = 1'b1;
    Channel_mask_i = mask;
    Period_cfg_i   = cur_period;
    @(negedge clk);
    Start_i        = 1'b0;
    Period_cfg_i   = 16'($urandom);
    Channel_mask_i = 4'($urandom);
  endtask

  // Entered on the first SELECT cycle; counts ADC-reset-high cycles until CONVERT.
  task automatic settle_phase(input int ch, input bit poke_start);
    int hi;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Adc_reset_o) break;
      hi++;
      if (hi == SETTLE + 1) begin
        ADC_valid_strb_i = 1'b1;
        On_counter_val_i = 16'($urandom);
      end
      if (poke_start && hi == 4) begin
        Start_i        = 1'b1;
        Channel_mask_i = 4'hF;
      end
      @(negedge clk);
      ADC_valid_strb_i = 1'b0;
      Start_i          = 1'b0;
    end
    chk("settle_len", hi, SETTLE + 1);
    chk("mux_sel", Mux_sel_o, ch);
    chk("busy_conv", Busy_o, 1);
    chk("valid_conv", Result_valid_o, 0);
  endtask

  // Drives one discarded strobe plus N_AVG samples; expected value is their mean.
  task automatic convert_phase(input int ch, input int mode, output logic [15:0] exp);
    longint      sum;
    logic [15:0] v;
    sum = 0;
    for (int k = 0; k <= N_AVG; k++) begin
      case (mode)
        1:       v = (ch == 0) ? ((k == 0) ? 16'd50 : 16'(96 + 4 * k)) : 16'($urandom);
        2:       v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      if (k > 0) sum += longint'(v);
      ADC_valid_strb_i = 1'b1;
      On_counter_val_i = v;
      Period_cfg_i     = 16'($urandom);
      @(negedge clk);
      ADC_valid_strb_i = 1'b0;
      On_counter_val_i = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    exp = 16'(sum / N_AVG);
  endtask

  task automatic output_phase(input int ch, input logic [15:0] exp, input int hold);
    chk("valid", Result_valid_o, 1);
    for (int c = 0; c < hold; c++) begin
      ADC_valid_strb_i = 1'($urandom);
      On_counter_val_i = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", Result_valid_o, 1);
      chk("hold_result", Result_o, exp);
      chk("hold_ch", Result_ch_o, ch);
      chk("hold_adc_rst", Adc_reset_o, 1);
    end
    ADC_valid_strb_i = 1'b0;
    chk("result", Result_o, exp);
    chk("result_ch", Result_ch_o, ch);
    chk("period", Period_counter_val_o, cur_period);
    Result_ready_i = 1'b1;
    @(negedge clk);
    Result_ready_i = 1'b0;
    chk("valid_drop", Result_valid_o, 0);
  endtask

  task automatic run_scan(input logic [3:0] mask, input int mode, input int hold_lo,
                          input int hold_hi, input bit poke);
    int          chans[$];
    logic [15:0] exp;
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) chans.push_back(i);
    start_scan(mask);
    chk("busy_start", Busy_o, 1);
    for (int j = 0; j < chans.size(); j++) begin
      settle_phase(chans[j], poke && (j == 0));
      convert_phase(chans[j], mode, exp);
      output_phase(chans[j], exp, $urandom_range(hold_hi, hold_lo));
    end
    chk("done_pulse", Scan_done_o, 1);
    chk("busy_done", Busy_o, 1);
    @(negedge clk);
    chk("done_clear", Scan_done_o, 0);
    chk("busy_idle", Busy_o, 0);
    chk("adc_rst_idle", Adc_reset_o, 1);
    done_exp++;
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int busy_hits;
    busy_hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (Busy_o || Result_valid_o) busy_hits++;
    end
    chk({tag, "_busy"}, busy_hits, 0);
    chk({tag, "_done_cnt"}, done_seen, done_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp;
    reset            = 1'b1;
    Start_i          = 1'b0;
    Abort_i          = 1'b0;
    Channel_mask_i   = 4'h0;
    Period_cfg_i     = 16'h0;
    On_counter_val_i = 16'h0;
    ADC_valid_strb_i = 1'b0;
    Result_ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    run_scan(4'b0101, 1, 10, 10, 1'b0);
    run_scan(4'b1111, 2, 0, 3, 1'b0);

    Start_i        = 1'b1;
    Channel_mask_i = 4'h0;
    @(negedge clk);
    Start_i = 1'b0;
    idle_quiet("mask0", 6);

    run_scan(4'b1010, 0, 0, 4, 1'b1);
    idle_quiet("poke", 15);

    start_scan(4'b0110);
    settle_phase(1, 1'b0);
    for (int k = 0; k < ((N_AVG > 1) ? 2 : 1); k++) begin
      ADC_valid_strb_i = 1'b1;
      On_counter_val_i = 16'($urandom);
      @(negedge clk);
      ADC_valid_strb_i = 1'b0;
    end
    Abort_i          = 1'b1;
    ADC_valid_strb_i = 1'b1;
    @(negedge clk);
    Abort_i          = 1'b0;
    ADC_valid_strb_i = 1'b0;
    chk("abort_busy", Busy_o, 0);
    chk("abort_adc_rst", Adc_reset_o, 1);
    chk("abort_valid", Result_valid_o, 0);
    idle_quiet("abort", 12);
    run_scan(4'b0110, 0, 0, 2, 1'b0);

    start_scan(4'b1000);
    settle_phase(3, 1'b0);
    convert_phase(3, 0, exp);
    chk("pre_reset_valid", Result_valid_o, 1);
    reset   = 1'b1;
    Abort_i = 1'b1;
    @(negedge clk);
    chk_reset_values("rst_out");
    reset   = 1'b0;
    Abort_i = 1'b0;
    idle_quiet("rst_out", 4);

    for (int s = 0; s < 6; s++) begin
      run_scan(4'($urandom_range(1, 15)), 0, 0, 5, 1'b0);
    end
    idle_quiet("final", 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
